enc8b10b_lanes: RTL and testbench
=================================

Name: enc8b10b_lanes

Overview:
- Parametrised 8b/10b encoder for the JESD204B TX link layer.
- Encodes OCTETS octets per clock.
- Tracks running disparity (RD) across octets within a cycle and across cycles, so the caller does not pick RD+/RD- tables.
- Sits between the TX scrambler/ILAS mux and the serializer; flags unsupported control characters.

Parameters:
- OCTETS, 4, octets encoded per clock (1..8); octet 0 is transmitted first.
- INIT_RD, 0, RD after reset (0 = RD-, 1 = RD+).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  i_data/i_k qualify this cycle.
- i_data  input  8*OCTETS  octet n at [8n+7:8n], HGFEDCBA with H as MSB.
- i_k  input  OCTETS  bit n = 1: octet n is a control word K; 0: data word D.
- o_valid  output  1  o_data qualifies this cycle.
- o_data  output  10*OCTETS  symbol n at [10n+9:10n], abcdeifghj with a as MSB.
- o_k_error  output  OCTETS  bit n = 1: octet n was flagged K but is not a legal K code.
- o_rd  output  1  RD after the last symbol currently on o_data (1 = RD+).

Behaviour:
- Reset (rst=1 at a clk edge):
  - o_valid=0, o_data=0, o_k_error=0, o_rd=INIT_RD.
  - Both pipeline stages are flushed.
  - rst has priority over i_valid in the same cycle; an in-flight word is discarded, not emitted.
- Latency is 2 clocks, fixed: i_valid at edge N gives o_valid at edge N+2. Throughput is one word per clock; there is no backpressure.
- Stage 1 (registered):
  - Per octet, look up both RD- and RD+ 6b codes for EDCBA and both 4b codes for HGF.
  - Record whether each sub-block is disparity-neutral.
  - Legal K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7.
  - An illegal K octet is replaced by K28.0 (neutral, keeps CDR toggling) and its k_error bit is set.
  - k_error is never set for D octets.
- Stage 2 (registered):
  - Disparity chain runs combinationally octet 0 -> OCTETS-1. Octet 0 starts from the stored RD register.
  - Per sub-block: select the RD- or RD+ variant from the current RD. A non-neutral sub-block flips RD; the 4b block uses the RD produced by its own 6b block.
  - D.x.7 alternate: use 0111 for x in {17,18,20} when RD-; use 1000 for x in {11,13,14} when RD+. Otherwise use primary 1110/0001.
  - D.x.3 and K28.x use the table entry as selected by RD.
  - On a valid word, the final chain RD is written to the RD register and driven on o_rd.
- Idle cycles (i_valid=0):
  - The RD register, o_rd and o_data hold their values; o_valid=0; o_k_error is cleared.
  - Idle bubbles never alter disparity.
- Back-to-back valid words: the RD register updates every cycle with no bubble needed. The chain of word N+1 sees the RD from word N.
- No arithmetic overflow is possible: RD is a single bit; every legal symbol has disparity in {-2, 0, +2}.

Decomposition:
- Package enc8b10b_pkg holds:
  - the 12 K-code localparams (K28_0..K30_7) and their 6b/4b RD- codes (RD+ is the bitwise complement where non-neutral);
  - RD_MINUS=1'b0 and RD_PLUS=1'b1;
  - the 5b/6b and 3b/4b table functions.
- One sub-module is natural: enc8b10b_octet.
  - Combinational; one octet plus i_rd in, 10-bit symbol plus o_rd and k_error out.
  - Instantiated OCTETS times in a generate loop, with o_rd of instance n wired to i_rd of instance n+1.
  - The pipeline registers and the RD register stay in the top-level block.

Test Plan:
- Reset then single K28.5 (OCTETS=1, INIT_RD=0): o_data=10'b0011111010 at edge +2, o_rd=1. A second K28.5 gives 10'b1100000101, o_rd=0.
- OCTETS=4, one word of K28.5 x4 from RD-: symbols 0011111010, 1100000101, 0011111010, 1100000101; o_rd=0; o_k_error=4'b0000.
- D0.0 from RD- gives 1001110100 with RD kept at -. Force RD+ via a prior K28.5; D0.0 then gives 0110001011 with RD kept at +.
  - D21.5 (8'hB5) gives 1010101010 regardless of RD.
- i_k=1 with i_data=8'h00 (illegal K): o_data=K28.0 for the current RD (RD- 0011110100, RD+ 1100001011), o_k_error bit=1, RD unchanged.
- Alternate-7 and idle handling:
  - From RD-, D17.7 (8'hF1) gives 1000110111.
  - Then i_valid=0 for 3 cycles: o_valid=0, o_rd held.
  - Next K28.5 uses the held RD.
- Assert rst in the cycle after i_valid: no o_valid pulse emerges and o_rd returns to INIT_RD on the next edge.

Source files
------------

// File: rtl/enc8b10b_pkg.sv
// 8b/10b code tables, K-code constants and
// the per-octet lookup bundle for the lane encoder.
package enc8b10b_pkg;

  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS  = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // 6b RD- codes of the K characters
  localparam logic [5:0] K28_6B = 6'b001111;
  localparam logic [5:0] K23_6B = 6'b111010;
  localparam logic [5:0] K27_6B = 6'b110110;
  localparam logic [5:0] K29_6B = 6'b101110;
  localparam logic [5:0] K30_6B = 6'b011110;
  // 4b code of Kxx.7 when its 4b block is entered at RD-
  localparam logic [3:0] KX7_4B = 4'b0111;

  // Both variants of each sub-block, indexed by the RD
  // entering that sub-block.
  typedef struct packed {
    logic [5:0] c6n;
    logic [5:0] c6p;
    logic       n6;
    logic [3:0] c4n;
    logic [3:0] c4p;
    logic       n4;
    logic       kerr;
  } oct_lk_t;

  function automatic logic [5:0] enc5b6b(
    input logic [4:0] x
  );
    logic [5:0] c;
    case (x)
      5'd0:  c = 6'b100111;
      5'd1:  c = 6'b011101;
      5'd2:  c = 6'b101101;
      5'd3:  c = 6'b110001;
      5'd4:  c = 6'b110101;
      5'd5:  c = 6'b101001;
      5'd6:  c = 6'b011001;
      5'd7:  c = 6'b111000;
      5'd8:  c = 6'b111001;
      5'd9:  c = 6'b100101;
      5'd10: c = 6'b010101;
      5'd11: c = 6'b110100;
      5'd12: c = 6'b001101;
      5'd13: c = 6'b101100;
      5'd14: c = 6'b011100;
      5'd15: c = 6'b010111;
      5'd16: c = 6'b011011;
      5'd17: c = 6'b100011;
      5'd18: c = 6'b010011;
      5'd19: c = 6'b110010;
      5'd20: c = 6'b001011;
      5'd21: c = 6'b101010;
      5'd22: c = 6'b011010;
      5'd23: c = 6'b111010;
      5'd24: c = 6'b110011;
      5'd25: c = 6'b100110;
      5'd26: c = 6'b010110;
      5'd27: c = 6'b110110;
      5'd28: c = 6'b001110;
      5'd29: c = 6'b101110;
      5'd30: c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // Data 3b/4b, primary code, 4b block entered at RD-
  function automatic logic [3:0] enc3b4b(
    input logic [2:0] y
  );
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b1001;
      3'd2: c = 4'b0101;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b1010;
      3'd6: c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // Control 3b/4b, 4b block entered at RD-;
  // the RD+ variant is always the complement.
  function automatic logic [3:0] enck4b(
    input logic [2:0] y
  );
    logic [3:0] c;
    case (y)
      3'd0: c = 4'b1011;
      3'd1: c = 4'b0110;
      3'd2: c = 4'b1010;
      3'd3: c = 4'b1100;
      3'd4: c = 4'b1101;
      3'd5: c = 4'b0101;
      3'd6: c = 4'b1001;
      default: c = KX7_4B;
    endcase
    return c;
  endfunction

  function automatic oct_lk_t lookup(
    input logic [7:0] d,
    input logic       k
  );
    oct_lk_t r;
    logic [4:0] x;
    logic [2:0] y;
    logic       legal;
    x = d[4:0];
    y = d[7:5];
    legal = (x == 5'd28) ||
      ((y == 3'd7) &&
       ((x == 5'd23) || (x == 5'd27) ||
        (x == 5'd29) || (x == 5'd30)));
    r.kerr = k && !legal;
    // illegal K becomes neutral K28.0
    if (r.kerr) begin
      x = 5'd28;
      y = 3'd0;
    end
    if (k && (x == 5'd28)) r.c6n = K28_6B;
    else                   r.c6n = enc5b6b(x);
    r.n6 = ($countones(r.c6n) == 3);
    if (r.n6 && (x != 5'd7)) r.c6p = r.c6n;
    else                     r.c6p = ~r.c6n;
    if (k) begin
      r.c4n = enck4b(y);
      r.c4p = ~r.c4n;
    end else begin
      r.c4n = enc3b4b(y);
      if (($countones(r.c4n) == 2) &&
          (y != 3'd3))
        r.c4p = r.c4n;
      else
        r.c4p = ~r.c4n;
      if (y == 3'd7) begin
        if ((x == 5'd17) || (x == 5'd18) ||
            (x == 5'd20))
          r.c4n = 4'b0111;
        if ((x == 5'd11) || (x == 5'd13) ||
            (x == 5'd14))
          r.c4p = 4'b1000;
      end
    end
    r.n4 = ($countones(r.c4n) == 2);
    return r;
  endfunction

endpackage

// File: rtl/enc8b10b_octet.sv
// Disparity-select stage for one octet: picks
// the RD-dependent 6b/4b codes and passes RD on.
module enc8b10b_octet
  import enc8b10b_pkg::*;
(
  input  oct_lk_t    i_lk,
  input  logic       i_rd,
  output logic [9:0] o_sym,
  output logic       o_rd,
  output logic       o_k_error
);

  logic [5:0] c6;
  logic [3:0] c4;
  logic       rd6;

  // 6b block from i_rd, 4b block from the 6b result
  always_comb begin
    c6    = (i_rd == RD_PLUS) ? i_lk.c6p : i_lk.c6n;
    rd6   = i_lk.n6 ? i_rd : ~i_rd;
    c4    = (rd6 == RD_PLUS) ? i_lk.c4p : i_lk.c4n;
    o_rd  = i_lk.n4 ? rd6 : ~rd6;
    o_sym = {c6, c4};
    o_k_error = i_lk.kerr;
  end

endmodule

// File: rtl/enc8b10b_lanes.sv
// Multi-octet 8b/10b encoder: registered table
// lookup, then registered disparity chain.
module enc8b10b_lanes
  import enc8b10b_pkg::*;
#(
  parameter int   OCTETS  = 4,
  parameter logic INIT_RD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [8*OCTETS-1:0]   i_data,
  input  logic [OCTETS-1:0]     i_k,
  output logic                  o_valid,
  output logic [10*OCTETS-1:0]  o_data,
  output logic [OCTETS-1:0]     o_k_error,
  output logic                  o_rd
);

  logic                      s1_vld_d, s1_vld_q;
  oct_lk_t [OCTETS-1:0]      s1_d, s1_q;
  logic [OCTETS:0]           rd_c;
  logic [10*OCTETS-1:0]      sym;
  logic [OCTETS-1:0]         kerr;
  logic                      vld_d, vld_q;
  logic                      rd_d, rd_q;
  logic [10*OCTETS-1:0]      data_d, data_q;
  logic [OCTETS-1:0]         kerr_d, kerr_q;

  // Stage 1: both RD variants per octet
  always_comb begin
    s1_vld_d = i_valid;
    for (int n = 0; n < OCTETS; n++)
      s1_d[n] = lookup(i_data[8*n +: 8], i_k[n]);
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
    end
  end

  assign rd_c[0] = rd_q;

  for (genvar n = 0; n < OCTETS; n++) begin : g_oct
    enc8b10b_octet u_oct (
      .i_lk      (s1_q[n]),
      .i_rd      (rd_c[n]),
      .o_sym     (sym[10*n +: 10]),
      .o_rd      (rd_c[n+1]),
      .o_k_error (kerr[n])
    );
  end

  // Stage 2: commit the chain only on valid words
  always_comb begin
    vld_d  = s1_vld_q;
    rd_d   = rd_q;
    data_d = data_q;
    kerr_d = '0;
    if (s1_vld_q) begin
      rd_d   = rd_c[OCTETS];
      data_d = sym;
      kerr_d = kerr;
    end
  end

  // Stage 2 register and running disparity
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      rd_q   <= INIT_RD;
      data_q <= '0;
      kerr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      kerr_q <= kerr_d;
    end
  end

  assign o_valid   = vld_q;
  assign o_data    = data_q;
  assign o_k_error = kerr_q;
  assign o_rd      = rd_q;

endmodule

// File: tb/tb_enc8b10b_lanes.sv
// Directed bench for enc8b10b_lanes: one-lane
// and four-lane instances, hand-computed symbols.
module tb_enc8b10b_lanes;

  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic        k1 = 1'b0;
  logic        o_valid1;
  logic [9:0]  o_data1;
  logic        o_kerr1;
  logic        o_rd1;

  logic        v4 = 1'b0;
  logic [31:0] d4 = '0;
  logic [3:0]  k4 = '0;
  logic        o_valid4;
  logic [39:0] o_data4;
  logic [3:0]  o_kerr4;
  logic        o_rd4;

  logic [12:0] got1, exp1;
  logic [45:0] got4, exp4;

  int cmp = 0;
  int err = 0;

  always #5 clk = ~clk;

  assign got1 = {o_valid1, o_rd1, o_kerr1, o_data1};
  assign got4 = {o_valid4, o_rd4, o_kerr4, o_data4};

  enc8b10b_lanes #(.OCTETS(1), .INIT_RD(1'b0)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (v1),
    .i_data    (d1),
    .i_k       (k1),
    .o_valid   (o_valid1),
    .o_data    (o_data1),
    .o_k_error (o_kerr1),
    .o_rd      (o_rd1)
  );

  enc8b10b_lanes #(.OCTETS(4), .INIT_RD(1'b0)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (v4),
    .i_data    (d4),
    .i_k       (k4),
    .o_valid   (o_valid4),
    .o_data    (o_data4),
    .o_k_error (o_kerr4),
    .o_rd      (o_rd4)
  );

  // one valid word on lane DUT, return when its output is visible
  task automatic pulse1(input logic [7:0] d, input logic k);
    @(negedge clk);
    v1 = 1'b1; d1 = d; k1 = k;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp1 = '0;
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL reset1 got %b exp %b", got1, exp1);
    end
    exp4 = '0;
    cmp++;
    if (got4 !== exp4) begin
      err++;
      $display("FAIL reset4 got %h exp %h", got4, exp4);
    end
    rst = 1'b0;
  endtask

  task automatic test_k285;
    @(negedge clk);
    v1 = 1'b1; d1 = 8'hBC; k1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    v1 = 1'b0; k1 = 1'b0;
    exp1 = {1'b1, 1'b1, 1'b0, K285N};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL k285_a got %b exp %b", got1, exp1);
    end
    @(negedge clk);
    exp1 = {1'b1, 1'b0, 1'b0, K285P};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL k285_b got %b exp %b", got1, exp1);
    end
    @(negedge clk);
    exp1 = {1'b0, 1'b0, 1'b0, K285P};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL k285_idle got %b exp %b", got1, exp1);
    end
  endtask

  task automatic test_lanes4;
    @(negedge clk);
    v4 = 1'b1; d4 = 32'hBCBCBCBC; k4 = 4'hF;
    @(negedge clk);
    d4 = 32'hF10000BC; k4 = 4'b0101;
    @(negedge clk);
    v4 = 1'b0; k4 = '0;
    exp4 = {1'b1, 1'b0, 4'b0000,
            K285P, K285N, K285P, K285N};
    cmp++;
    if (got4 !== exp4) begin
      err++;
      $display("FAIL lanes4_k285 got %h exp %h", got4, exp4);
    end
    @(negedge clk);
    exp4 = {1'b1, 1'b0, 4'b0100,
            10'b1000110001, 10'b1100001011,
            10'b0110001011, K285N};
    cmp++;
    if (got4 !== exp4) begin
      err++;
      $display("FAIL lanes4_mix got %h exp %h", got4, exp4);
    end
    @(negedge clk);
    exp4 = {1'b0, 1'b0, 4'b0000,
            10'b1000110001, 10'b1100001011,
            10'b0110001011, K285N};
    cmp++;
    if (got4 !== exp4) begin
      err++;
      $display("FAIL lanes4_idle got %h exp %h", got4, exp4);
    end
  endtask

  task automatic test_dx;
    pulse1(8'h00, 1'b0);
    exp1 = {1'b1, 1'b0, 1'b0, 10'b1001110100};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d00_rdm got %b exp %b", got1, exp1);
    end
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b1, 1'b0, K285N};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL dx_k285 got %b exp %b", got1, exp1);
    end
    pulse1(8'h00, 1'b0);
    exp1 = {1'b1, 1'b1, 1'b0, 10'b0110001011};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d00_rdp got %b exp %b", got1, exp1);
    end
    pulse1(8'hB5, 1'b0);
    exp1 = {1'b1, 1'b1, 1'b0, 10'b1010101010};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d215_rdp got %b exp %b", got1, exp1);
    end
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b0, 1'b0, K285P};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL dx_k285p got %b exp %b", got1, exp1);
    end
    pulse1(8'hB5, 1'b0);
    exp1 = {1'b1, 1'b0, 1'b0, 10'b1010101010};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d215_rdm got %b exp %b", got1, exp1);
    end
  endtask

  task automatic test_illegal_k;
    pulse1(8'h00, 1'b1);
    exp1 = {1'b1, 1'b0, 1'b1, 10'b0011110100};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL badk_rdm got %b exp %b", got1, exp1);
    end
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b1, 1'b0, K285N};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL badk_k285 got %b exp %b", got1, exp1);
    end
    pulse1(8'h00, 1'b1);
    exp1 = {1'b1, 1'b1, 1'b1, 10'b1100001011};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL badk_rdp got %b exp %b", got1, exp1);
    end
    @(negedge clk);
    exp1 = {1'b0, 1'b1, 1'b0, 10'b1100001011};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL badk_idle got %b exp %b", got1, exp1);
    end
    pulse1(8'hF7, 1'b1);
    exp1 = {1'b1, 1'b1, 1'b0, 10'b0001010111};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL k237_rdp got %b exp %b", got1, exp1);
    end
  endtask

  task automatic test_alt7_idle;
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b0, 1'b0, K285P};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL alt_k285 got %b exp %b", got1, exp1);
    end
    pulse1(8'hF1, 1'b0);
    exp1 = {1'b1, 1'b1, 1'b0, 10'b1000110111};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d177_rdm got %b exp %b", got1, exp1);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp1 = {1'b0, 1'b1, 1'b0, 10'b1000110111};
      cmp++;
      if (got1 !== exp1) begin
        err++;
        $display("FAIL idle%0d got %b exp %b", i, got1, exp1);
      end
    end
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b0, 1'b0, K285P};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL idle_k285 got %b exp %b", got1, exp1);
    end
    pulse1(8'hBC, 1'b1);
    pulse1(8'hEB, 1'b0);
    exp1 = {1'b1, 1'b0, 1'b0, 10'b1101001000};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d117_rdp got %b exp %b", got1, exp1);
    end
    pulse1(8'hBC, 1'b1);
    pulse1(8'hF1, 1'b0);
    exp1 = {1'b1, 1'b0, 1'b0, 10'b1000110001};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL d177_rdp got %b exp %b", got1, exp1);
    end
  endtask

  task automatic test_reset_flush;
    pulse1(8'hBC, 1'b1);
    exp1 = {1'b1, 1'b1, 1'b0, K285N};
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL flush_pre got %b exp %b", got1, exp1);
    end
    @(negedge clk);
    v1 = 1'b1; d1 = 8'hBC; k1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp1 = '0;
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL flush_rst got %b exp %b", got1, exp1);
    end
    @(negedge clk);
    cmp++;
    if (got1 !== exp1) begin
      err++;
      $display("FAIL flush_after got %b exp %b", got1, exp1);
    end
  endtask

  initial begin
    test_reset;
    test_k285;
    test_lanes4;
    test_dx;
    test_illegal_k;
    test_alt7_idle;
    test_reset_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, err);
    $finish;
  end

endmodule
